// File: rtl/ctl_regs_pkg.sv
// Field map of the software control word and the sync FSM encoding,
// shared by every block fed from the OPB control register.
package ctl_regs_pkg;

    localparam int CTL_W             = 32;
    localparam int CTL_ARM_BIT       = 0;
    localparam int CTL_SOFT_SYNC_BIT = 1;
    localparam int CTL_CNT_RST_BIT   = 2;
    localparam int CTL_PULSE_BITS    = 3;
    localparam int LEVEL_LSB         = 16;
    localparam int LEVEL_MSB         = 31;
    localparam int LEVEL_W           = LEVEL_MSB - LEVEL_LSB + 1;
    localparam int OFFS_W            = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2
    } sync_state_e;

    // Countdown reload value; the edge cycle itself accounts for one cycle of the offset.
    function automatic logic [OFFS_W-1:0] offs_reload(input int unsigned offset);
        logic [OFFS_W-1:0] v;
        v = (offset == 0) ? '0 : OFFS_W'(offset - 1);
        return v;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, followed by a third flop
// that turns each rising edge into a single-cycle pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= async_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise_pulse = s2_reg & ~s3_reg;

endmodule

// File: rtl/ctl_reg_sync_decoder.sv
// Filters the software control word for stability and decodes it into
// command pulses, level controls and an armed / 1PPS-aligned sync generator.
module ctl_reg_sync_decoder
    import ctl_regs_pkg::*;
#(
    parameter int unsigned SYNC_OFFSET = 16,
    parameter int          CNT_W       = 32
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    input  logic [CTL_W-1:0]   ctl_word,
    input  logic               ext_sync,
    output logic               sync_out,
    output logic               armed,
    output logic               cnt_rst_pulse,
    output logic [LEVEL_W-1:0] level_ctrl,
    output logic [CNT_W-1:0]   sync_count
);

    localparam bit                ZERO_OFFSET = (SYNC_OFFSET == 0);
    localparam logic [OFFS_W-1:0] OFFS_LOAD   = offs_reload(SYNC_OFFSET);

    logic [CTL_W-1:0]          samp_reg;
    logic [CTL_W-1:0]          acc_reg;
    logic [CTL_PULSE_BITS-1:0] acc_d_reg;
    logic [CTL_PULSE_BITS-1:0] rise_next;
    logic [CTL_PULSE_BITS-1:0] rise_reg;

    // A word is accepted only once it has been seen unchanged on two consecutive edges.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            samp_reg  <= '0;
            acc_reg   <= '0;
            acc_d_reg <= '0;
            rise_reg  <= '0;
        end else begin
            samp_reg <= ctl_word;
            if (samp_reg == ctl_word) begin
                acc_reg <= samp_reg;
            end
            acc_d_reg <= acc_reg[CTL_PULSE_BITS-1:0];
            rise_reg  <= rise_next;
        end
    end

    generate
        for (genvar gi = 0; gi < CTL_PULSE_BITS; gi++) begin : g_rise
            assign rise_next[gi] = acc_reg[gi] & ~acc_d_reg[gi];
        end
    endgenerate

    logic arm_rise;
    logic soft_rise;
    logic unused_reserved;

    assign arm_rise        = rise_reg[CTL_ARM_BIT];
    assign soft_rise       = rise_reg[CTL_SOFT_SYNC_BIT];
    assign cnt_rst_pulse   = rise_reg[CTL_CNT_RST_BIT];
    assign level_ctrl      = acc_reg[LEVEL_MSB:LEVEL_LSB];
    assign unused_reserved = ^acc_reg[LEVEL_LSB-1:CTL_PULSE_BITS];

    logic ext_edge;

    sync_edge_detect u_ext_sync (
        .clk        (user_clk),
        .rst_n      (user_rst_n),
        .async_in   (ext_sync),
        .rise_pulse (ext_edge)
    );

    sync_state_e       state_reg;
    sync_state_e       state_next;
    logic [OFFS_W-1:0] offs_cnt_reg;
    logic [OFFS_W-1:0] offs_cnt_next;
    logic              sync_fire;
    logic              armed_now;
    logic              sync_out_reg;
    logic [CNT_W-1:0]  sync_count_reg;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_reg    <= IDLE;
            offs_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            offs_cnt_reg <= offs_cnt_next;
        end
    end

    // Command rises arriving outside IDLE are dropped so a running offset is never restarted.
    always_comb begin
        state_next    = state_reg;
        offs_cnt_next = offs_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (arm_rise) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (ext_edge) begin
                    if (ZERO_OFFSET) begin
                        state_next = IDLE;
                    end else begin
                        state_next    = COUNT;
                        offs_cnt_next = OFFS_LOAD;
                    end
                end
            end
            COUNT: begin
                if (offs_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    offs_cnt_next = offs_cnt_reg - OFFS_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        armed_now = 1'b0;
        sync_fire = 1'b0;
        unique case (state_reg)
            IDLE: begin
                sync_fire = soft_rise & ~arm_rise;
            end
            ARMED: begin
                armed_now = 1'b1;
                sync_fire = ext_edge & ZERO_OFFSET;
            end
            COUNT: begin
                armed_now = 1'b1;
                sync_fire = (offs_cnt_reg == '0);
            end
            default: begin
                armed_now = 1'b0;
                sync_fire = 1'b0;
            end
        endcase
    end

    // Software clear takes priority over a coincident sync increment.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            sync_out_reg   <= 1'b0;
            sync_count_reg <= '0;
        end else begin
            sync_out_reg <= sync_fire;
            if (cnt_rst_pulse) begin
                sync_count_reg <= '0;
            end else if (sync_out_reg) begin
                sync_count_reg <= sync_count_reg + CNT_W'(1);
            end
        end
    end

    assign sync_out   = sync_out_reg;
    assign armed      = armed_now;
    assign sync_count = sync_count_reg;

endmodule

// File: tb/tb_ctl_reg_sync_decoder.sv
// Scenario tests plus a random soak for ctl_reg_sync_decoder, checked against
// an event-level model of word acceptance, command rises and the sync schedule.
module tb_ctl_reg_sync_decoder;

    localparam int unsigned OFFSET = 16;
    localparam int          CW     = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   ctl_word = '0;
    logic          ext_sync = 1'b0;
    logic          sync_out;
    logic          armed;
    logic          cnt_rst_pulse;
    logic [15:0]   level_ctrl;
    logic [CW-1:0] sync_count;

    int n_checks = 0;
    int n_fail   = 0;

    ctl_reg_sync_decoder #(.SYNC_OFFSET(OFFSET), .CNT_W(CW)) dut (
        .user_clk      (clk),
        .user_rst_n    (rst_n),
        .ctl_word      (ctl_word),
        .ext_sync      (ext_sync),
        .sync_out      (sync_out),
        .armed         (armed),
        .cnt_rst_pulse (cnt_rst_pulse),
        .level_ctrl    (level_ctrl),
        .sync_count    (sync_count)
    );

    always #5 clk = ~clk;

    // Reference model: accepted-word history, synchronized ext history and a fire schedule.
    logic [31:0]   m_cw_prev;
    logic [31:0]   m_acc1;
    logic [31:0]   m_acc2;
    logic          m_e1, m_e2, m_e3;
    logic [2:0]    m_pulse;
    logic          m_sync;
    logic          m_armed;
    int            m_fire_at;
    int            m_t;
    logic [CW-1:0] m_cnt;

    task automatic model_clear();
        m_cw_prev = '0; m_acc1 = '0; m_acc2 = '0;
        m_e1 = 1'b0; m_e2 = 1'b0; m_e3 = 1'b0;
        m_pulse = '0; m_sync = 1'b0; m_armed = 1'b0;
        m_fire_at = -1; m_t = 0; m_cnt = '0;
    endtask

    task automatic model_step();
        logic [2:0]  p_before;
        logic        s_before;
        logic        e_seen;
        logic [31:0] acc_new;
        if (!rst_n) begin
            model_clear();
            return;
        end
        m_t++;
        p_before = m_pulse;
        s_before = m_sync;
        e_seen   = m_e2 & ~m_e3;
        if (p_before[2]) m_cnt = '0;
        else if (s_before) m_cnt = m_cnt + CW'(1);
        m_sync = 1'b0;
        if (!m_armed) begin
            if (p_before[0]) begin
                m_armed = 1'b1;
                m_fire_at = -1;
            end else if (p_before[1]) begin
                m_sync = 1'b1;
            end
        end else if (m_fire_at < 0 && e_seen) begin
            m_fire_at = m_t + int'(OFFSET);
        end
        if (m_armed && m_fire_at == m_t) begin
            m_sync = 1'b1;
            m_armed = 1'b0;
            m_fire_at = -1;
        end
        m_pulse = m_acc1[2:0] & ~m_acc2[2:0];
        acc_new = (ctl_word == m_cw_prev) ? ctl_word : m_acc1;
        m_acc2 = m_acc1;
        m_acc1 = acc_new;
        m_cw_prev = ctl_word;
        m_e3 = m_e2; m_e2 = m_e1; m_e1 = ext_sync;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ctl_word = '0;
        ext_sync = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ctl_word = 32'h0000_0007;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sync_out, armed, cnt_rst_pulse, level_ctrl} !== 19'd0 || sync_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got so=%b arm=%b crp=%b lvl=%h cnt=%0d expected all 0",
                     sync_out, armed, cnt_rst_pulse, level_ctrl, sync_count);
        end
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({sync_out, cnt_rst_pulse} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_first_cycle: got so=%b crp=%b expected 0 0", sync_out, cnt_rst_pulse);
        end
        tick(); tick();
        n_checks++;
        if (cnt_rst_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cnt_rst_rise: got %b expected 1", cnt_rst_pulse);
        end
        tick();
        n_checks++;
        if ({armed, sync_out, cnt_rst_pulse} !== 3'b100) begin
            n_fail++;
            $display("FAIL arm_wins_over_soft: got arm=%b so=%b crp=%b expected 1 0 0",
                     armed, sync_out, cnt_rst_pulse);
        end
        $display("test_reset done");
    endtask

    task automatic test_arm_latency();
        logic exp;
        do_reset();
        tick(); tick();
        ctl_word = 32'h0000_0001;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = (i >= 4);
            n_checks++;
            if (armed !== exp || sync_out !== 1'b0) begin
                n_fail++;
                $display("FAIL arm_latency edge %0d: got arm=%b so=%b expected arm=%b so=0",
                         i, armed, sync_out, exp);
            end
        end
        n_checks++;
        if (sync_count !== '0) begin
            n_fail++;
            $display("FAIL arm_count: got %0d expected 0", sync_count);
        end
        $display("test_arm_latency done");
    endtask

    task automatic test_ext_offset();
        int first_hit = -1;
        int hits = 0;
        ext_sync = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (sync_out === 1'b1) begin
                hits++;
                if (first_hit < 0) first_hit = i;
            end
            n_checks++;
            if (sync_out !== m_sync) begin
                n_fail++;
                $display("FAIL ext_offset_cycle %0d: got so=%b expected %b", i, sync_out, m_sync);
            end
        end
        ext_sync = 1'b0;
        tick(); tick();
        n_checks++;
        if (hits != 1 || first_hit != 19) begin
            n_fail++;
            $display("FAIL ext_offset_timing: got hits=%0d first=%0d expected hits=1 first=19", hits, first_hit);
        end
        n_checks++;
        if (armed !== 1'b0 || sync_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL ext_offset_after: got arm=%b cnt=%0d expected arm=0 cnt=1", armed, sync_count);
        end
        $display("test_ext_offset done: sync_out %0d cycles after ext_sync rise", first_hit);
    endtask

    task automatic test_soft_sync();
        int hits = 0;
        do_reset();
        for (int ph = 0; ph < 5; ph++) begin
            ctl_word = (ph % 2 == 1) ? 32'h0000_0002 : 32'h0000_0000;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (sync_out === 1'b1) hits++;
                n_checks++;
                if (sync_out !== m_sync || armed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL soft_sync_cycle ph%0d k%0d: got so=%b arm=%b expected so=%b arm=0",
                             ph, k, sync_out, armed, m_sync);
                end
            end
        end
        n_checks++;
        if (hits != 2 || sync_count !== CW'(2)) begin
            n_fail++;
            $display("FAIL soft_sync_total: got hits=%0d cnt=%0d expected 2 2", hits, sync_count);
        end
        $display("test_soft_sync done");
    endtask

    task automatic test_toggle_filter();
        logic [15:0] lvl;
        logic [31:0] word;
        do_reset();
        tick(); tick(); tick();
        lvl = 16'($urandom_range(1, 65535));
        word = {lvl, 16'h0000};
        for (int i = 0; i < 50; i++) begin
            ctl_word = (i % 2 == 0) ? word : 32'h0000_0007;
            tick();
            n_checks++;
            if ({armed, sync_out, cnt_rst_pulse, level_ctrl} !== 19'd0) begin
                n_fail++;
                $display("FAIL toggle_reject %0d: got arm=%b so=%b crp=%b lvl=%h expected all 0",
                         i, armed, sync_out, cnt_rst_pulse, level_ctrl);
            end
        end
        ctl_word = word;
        tick();
        n_checks++;
        if (level_ctrl !== 16'h0000) begin
            n_fail++;
            $display("FAIL toggle_hold_n1: got %h expected 0000", level_ctrl);
        end
        tick();
        n_checks++;
        if (level_ctrl !== lvl) begin
            n_fail++;
            $display("FAIL toggle_hold_n2: got %h expected %h", level_ctrl, lvl);
        end
        $display("test_toggle_filter done: level %h", lvl);
    endtask

    task automatic test_clear_collision();
        do_reset();
        ctl_word = 32'h0000_0001;
        repeat (5) tick();
        ext_sync = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 16) ctl_word = 32'h0000_0005;
            if (i == 19) begin
                n_checks++;
                if ({sync_out, cnt_rst_pulse} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL collision_align: got so=%b crp=%b expected 1 1", sync_out, cnt_rst_pulse);
                end
            end
        end
        n_checks++;
        if (sync_count !== '0 || m_cnt !== '0) begin
            n_fail++;
            $display("FAIL collision_clear_wins: got %0d expected 0", sync_count);
        end
        ext_sync = 1'b0;
        $display("test_clear_collision done");
    endtask

    task automatic test_reset_in_count();
        int hits = 0;
        do_reset();
        ctl_word = 32'h0000_0001;
        repeat (5) tick();
        ext_sync = 1'b1;
        repeat (13) tick();
        n_checks++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL count_armed: got %b expected 1", armed);
        end
        rst_n = 1'b0;
        ctl_word = '0;
        #1;
        n_checks++;
        if ({sync_out, armed, cnt_rst_pulse, level_ctrl} !== 19'd0 || sync_count !== '0) begin
            n_fail++;
            $display("FAIL count_abort: got so=%b arm=%b crp=%b lvl=%h cnt=%0d expected all 0",
                     sync_out, armed, cnt_rst_pulse, level_ctrl, sync_count);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ext_sync = ((i / 10) % 2 == 1);
            tick();
            n_checks++;
            if ({sync_out, armed} !== 2'b00) begin
                n_fail++;
                $display("FAIL post_reset_idle %0d: got so=%b arm=%b expected 0 0", i, sync_out, armed);
            end
        end
        ctl_word = 32'h0000_0001;
        ext_sync = 1'b0;
        repeat (5) tick();
        ext_sync = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sync_out === 1'b1) hits++;
        end
        n_checks++;
        if (hits != 1) begin
            n_fail++;
            $display("FAIL rearm_sync: got %0d pulses expected 1", hits);
        end
        ext_sync = 1'b0;
        $display("test_reset_in_count done");
    endtask

    task automatic test_random();
        int hold_cw = 0;
        int hold_ext = 0;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (hold_cw == 0) begin
                ctl_word = {16'($urandom), 13'($urandom), 3'($urandom)};
                hold_cw = $urandom_range(1, 8);
            end
            if (hold_ext == 0) begin
                ext_sync = 1'($urandom_range(0, 1));
                hold_ext = $urandom_range(1, 40);
            end
            tick();
            hold_cw--;
            hold_ext--;
            if (m_sync) pulses++;
            n_checks++;
            if ({sync_out, armed, cnt_rst_pulse, level_ctrl} !== {m_sync, m_armed, m_pulse[2], m_acc1[31:16]}) begin
                n_fail++;
                $display("FAIL random_outputs %0d: got so=%b arm=%b crp=%b lvl=%h expected so=%b arm=%b crp=%b lvl=%h",
                         i, sync_out, armed, cnt_rst_pulse, level_ctrl, m_sync, m_armed, m_pulse[2], m_acc1[31:16]);
            end
            n_checks++;
            if (sync_count !== m_cnt) begin
                n_fail++;
                $display("FAIL random_count %0d: got %0d expected %0d", i, sync_count, m_cnt);
            end
        end
        $display("test_random done: %0d sync pulses", pulses);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_arm_latency();
        test_ext_offset();
        test_soft_sync();
        test_toggle_filter();
        test_clear_collision();
        test_reset_in_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctl_reg_sync_decoder.md
Name: ctl_reg_sync_decoder

Overview:
- Sits directly downstream of the OPB software control register in the F-engine control path.
- Consumes the 32-bit control word the register presents in the user_clk domain and filters it for stability.
- Turns software-written bits into single-cycle pulses, level controls and an arm/1PPS-aligned sync generator.
- Drives the F-engine sync distribution and the sync counter readback.

Parameters:
- SYNC_OFFSET, 16: cycles between the detected external sync edge and sync_out; 0 to 65535.
- CNT_W, 32: width of sync_count.

Ports:
- user_clk  in  1  fabric clock; all logic in this domain.
- user_rst_n  in  1  asynchronous, active-low reset.
- ctl_word  in  32  control word from the software register.
- ext_sync  in  1  external 1PPS; asynchronous to user_clk.
- sync_out  out  1  one-cycle sync pulse to the F-engine.
- armed  out  1  high while waiting for or counting from an external edge.
- cnt_rst_pulse  out  1  one-cycle pulse; software counter clear.
- level_ctrl  out  16  accepted ctl_word[31:16] (TVG enable, GPU destination select, etc.).
- sync_count  out  CNT_W  number of sync_out pulses emitted; wraps.

Behaviour:
- Reset: user_clk is the single clock; user_rst_n is asynchronous, active-low.
  - All outputs go to 0 and the FSM to IDLE.
  - Filter registers, edge history and synchronizer flops go to 0.
  - No pulse may be generated on the first cycle after reset release.
- Control-word bit map:
  - bit0 ARM, bit1 SOFT_SYNC, bit2 CNT_RST: act on rising edge only.
  - bits[7:3] reserved, ignored.
  - bits[15:8] reserved, ignored.
  - bits[31:16] level_ctrl.
- Stability filter:
  - samp is loaded with ctl_word every cycle.
  - acc is loaded with samp only when samp == ctl_word.
  - A change stable from edge N therefore updates acc at edge N+2.
  - A word that toggles every cycle is never accepted; acc holds its old value.
- Edge detection: acc_d is acc delayed one cycle.
  - A rising edge on an acc control bit is a registered pulse at edge N+3, i.e. 3 cycles after a stable input change.
  - level_ctrl is driven directly from acc[31:16] (updates at N+2).
- cnt_rst_pulse: one cycle, on rising edge of CNT_RST.
- ext_sync path:
  - 2-flop synchronizer, then a third flop for the edge.
  - ext_edge = s2 & ~s3, one cycle per rising edge.
  - A high level that persists generates only one edge.
- FSM states: IDLE, ARMED, COUNT.
  - IDLE:
    - On ARM rise, go to ARMED.
    - Otherwise, on SOFT_SYNC rise, sync_out = 1 the next cycle and stay in IDLE.
  - ARMED:
    - On ext_edge with SYNC_OFFSET == 0, sync_out the next cycle, then IDLE.
    - On ext_edge with SYNC_OFFSET > 0, go to COUNT with offs_cnt = SYNC_OFFSET - 1.
  - COUNT:
    - offs_cnt decrements each cycle.
    - Leaving COUNT when offs_cnt == 0: sync_out = 1 on the next cycle, then IDLE.
    - Timing: sync_out is asserted exactly SYNC_OFFSET+1 cycles after the cycle in which ext_edge is high.
  - armed = 1 in ARMED and COUNT.
  - ARM rise while in ARMED or COUNT: ignored; the offset is not restarted.
  - SOFT_SYNC rise while in ARMED or COUNT: ignored; no extra pulse.
  - ARM and SOFT_SYNC rising in the same cycle in IDLE: ARM wins, go to ARMED, no soft pulse.
  - ext_edge in IDLE: ignored.
- sync_count:
  - Increments by 1 in the cycle sync_out is high; wraps from all-ones to 0.
  - cnt_rst_pulse clears it to 0.
  - If clear and increment coincide, clear wins and the result is 0.
- Reset mid-operation: an asserted user_rst_n in COUNT aborts immediately. No sync_out is emitted after release until re-armed.

Decomposition:
- Shared package ctl_regs_pkg holds:
  - bit-position constants CTL_ARM_BIT=0, CTL_SOFT_SYNC_BIT=1, CTL_CNT_RST_BIT=2;
  - LEVEL_LSB=16, LEVEL_MSB=31;
  - the FSM state enum (IDLE, ARMED, COUNT).
- One sub-module is natural: sync_edge_detect, the 2-flop synchronizer plus rising-edge pulse.
  - Instanced for ext_sync.
  - Reusable by the other control paths fed from the software register block.

Test Plan:
- Reset, then drive ctl_word=0x00000001 stable: armed=1 from the 4th edge after the input change; no sync_out; sync_count=0.
- Armed with SYNC_OFFSET=16, raise ext_sync for 100 cycles: exactly one sync_out, 17 cycles after ext_edge; armed=0 after; sync_count=1.
- From IDLE, write 0x0, then 0x2 twice: sync_out once per 0→1 transition, 2 pulses total; sync_count=2.
- ctl_word alternating 0x00000007/0x00A50000 every cycle for 50 cycles: acc unchanged, no pulses, level_ctrl unchanged. Then hold 0x00A50000: level_ctrl=0x00A5 at N+2.
- Write 0x4 in the same cycle that sync_out fires: sync_count=0 afterwards, not 1.
- Assert user_rst_n=0 while in COUNT (offs_cnt=5), release: all outputs 0; ext_sync edges produce no sync_out until ARM rises again.
